// File: rtl/ram_pkg.sv
// Shared types and defaults for the RAM-side responder and its controller.
package ram_pkg;

  typedef enum logic [0:0] {INIT, RUN} state_e;

  localparam int DIV_DEF = 4;
  localparam int ADW_DEF = 4;
  localparam int DIW_DEF = 16;
  localparam int DEPTH   = 1 << ADW_DEF;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/ram_resp_if.sv
// RAM command/response port between the write/read controller and ram_resp.
interface ram_resp_if
  import ram_pkg::*;
#(
  parameter int DIW = DIW_DEF,
  parameter int DOW = DIW_DEF,
  parameter int ADW = ADW_DEF
);
  logic           en;
  logic           we;
  logic [ADW-1:0] addr;
  logic [DIW-1:0] din;
  logic [DOW-1:0] dout;
  logic           dout_vld;
  logic           busy;

  modport master (output en, we, addr, din, input dout, dout_vld, busy);
  modport slave  (input en, we, addr, din, output dout, dout_vld, busy);
endinterface

// File: rtl/rd_pipe.sv
// Tick-advanced {valid, data} delay line; shared with the controller-side read delay chain.
module rd_pipe #(
  parameter int W      = 16,
  parameter int RD_LAT = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift,
  input  logic         valid_in,
  input  logic [W-1:0] data_in,
  output logic         valid_out,
  output logic [W-1:0] data_out
);
  logic [RD_LAT-1:0] vld;
  logic [W-1:0]      dat [RD_LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (shift) begin
      vld[0] <= valid_in;
      for (int unsigned i = 1; i < RD_LAT; i++) vld[i] <= vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (shift) begin
      dat[0] <= data_in;
      for (int unsigned i = 1; i < RD_LAT; i++) dat[i] <= dat[i-1];
    end
  end

  assign valid_out = vld[RD_LAT-1];
  assign data_out  = dat[RD_LAT-1];
endmodule

// File: rtl/ram_resp.sv
// RAM-side responder: clears its array after reset, then serves commands sampled once per RAM period.
module ram_resp
  import ram_pkg::*;
#(
  parameter int DIW    = 16,
  parameter int DOW    = 16,
  parameter int ADW    = 4,
  parameter int DIV    = DIV_DEF,
  parameter int RD_LAT = 3
) (
  input logic       clk,
  input logic       rst_n,
  ram_resp_if.slave bus
);
  localparam int PHW    = clog2(DIV);
  localparam int NWORDS = 1 << ADW;

  logic [PHW-1:0] ph;
  logic           tick;
  state_e         state_q, state_d;
  logic [ADW-1:0] init_addr;
  logic [DIW-1:0] mem [NWORDS];

  logic           mem_we;
  logic [ADW-1:0] mem_waddr;
  logic [DIW-1:0] mem_wdata;
  logic           rd_req;
  logic           pipe_vld;
  logic [DIW-1:0] pipe_data;
  logic [DOW-1:0] rd_word;
  logic [DOW-1:0] dout_q;
  logic           dout_vld_q;

  assign tick = (ph == PHW'(DIV - 1));

  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_waddr = bus.addr;
    mem_wdata = bus.din;
    rd_req    = 1'b0;
    case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = init_addr;
        mem_wdata = '0;
        if (init_addr == '1) state_d = RUN;
      end
      RUN: begin
        if (tick && bus.en) begin
          if (bus.we) mem_we = 1'b1;
          else        rd_req = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ph         <= '0;
      state_q    <= INIT;
      init_addr  <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      ph         <= ph + PHW'(1);
      state_q    <= state_d;
      if (state_q == INIT) init_addr <= init_addr + ADW'(1);
      dout_vld_q <= tick && pipe_vld;
      if (tick && pipe_vld) dout_q <= rd_word;
    end
  end

  // Array has no reset of its own; INIT rewrites every word after each reset.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  rd_pipe #(
    .W      (DIW),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift     (tick),
    .valid_in  (rd_req),
    .data_in   (mem[bus.addr]),
    .valid_out (pipe_vld),
    .data_out  (pipe_data)
  );

  if (DOW <= DIW) begin : g_trunc
    assign rd_word = pipe_data[DOW-1:0];
  end else begin : g_zext
    assign rd_word = {{(DOW - DIW){1'b0}}, pipe_data};
  end

  assign bus.dout     = dout_q;
  assign bus.dout_vld = dout_vld_q;
  assign bus.busy     = (state_q == INIT);
endmodule
